// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline.
// It decides, every cycle, whether each stage register (PC, IF/ID, ID/EX,
// EX/MEM, MEM/WB) captures new data, holds its value, or loads a bubble.
// It carries no datapath.
//
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds two saturating
// performance counters (perf_stall_cyc, perf_flush_cnt).
//
// Handshake note: this block has no valid/ready channel of its own. mem_req
// and mem_ready are observed, not answered. An access holds the pipeline
// whenever mem_req is high and mem_ready is low in the same cycle.
//
// dbg_state exposes the FSM state: 0 = RUN, 1 = MDU_BUSY.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_MAX_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_br_taken,
    input  logic                  ex_mdu_start,
    input  logic                  mdu_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  mdu_timeout,
    output logic                  dbg_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;

    // The counter only has to hold values up to MDU_MAX_CYC-1.
    localparam int CW = (MDU_MAX_CYC > 2) ? $clog2(MDU_MAX_CYC) : 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(MDU_MAX_CYC - 1);

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [CW-1:0] wdog_cnt;
    logic          wdog_inc;
    logic          mem_stall;
    logic          load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_is_load && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    assign dbg_state = state[0];

    // Priority resolution of hazards into stage enables and flushes.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_next   = state;
        wdog_inc     = 1'b0;
        if (!rst_n) begin
            // Stage registers reset themselves; keep every control quiet.
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            state_next = RUN;
        end else if (mem_stall) begin
            // Freeze everything up to MEM; WB gets a bubble. A branch in EX
            // is held and takes effect once the stall clears.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state == MDU_BUSY) begin
            if (!mdu_done) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                wdog_inc     = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (ex_br_taken) begin
            // The instruction in ID is squashed too, so load-use is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_mdu_start) begin
            // A same-cycle done means a one-cycle operation: no stall at all.
            if (!mdu_done) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                state_next   = MDU_BUSY;
            end
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // State, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            wdog_cnt    <= '0;
            mdu_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (wdog_inc) begin
                if (wdog_cnt == WDOG_LAST) begin
                    mdu_timeout <= 1'b1;
                    state       <= RUN;
                    wdog_cnt    <= '0;
                end else begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
            end else if (state_next == RUN) begin
                wdog_cnt <= '0;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Saturating counters: stalled-front-end cycles and branch squashes.
    // if_id_flush is raised only by a taken-branch redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_en && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (if_id_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
// It runs directed hazard scenarios, then randomized traffic.
// Every output is compared against a reference model held in the bench.
module tb_pipe_hazard_ctrl;

  localparam int AW  = 5;
  localparam int MAX = 8;
  localparam int W   = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0;
  logic          ex_br_taken = 0, ex_mdu_start = 0, mdu_done = 0;
  logic          mem_req = 0, mem_ready = 0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          mdu_timeout, dbg_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0]   perf_stall_cyc, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MDU_MAX_CYC(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mdu_timeout(mdu_timeout), .dbg_state(dbg_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The model tracks whether an MDU operation is outstanding, how many
  // non-stalled cycles it has spent waiting, and the sticky error.
  bit m_busy = 0, m_to = 0;
  int m_wait = 0;
  bit n_busy, n_to;
  int n_wait;
  int m_stalls = 0, m_flushes = 0;
  int n_stalls, n_flushes;

  // Builds the expected {en[4:0], flush[3:0], timeout, state} for the
  // current inputs and works out what the model state will be after the edge.
  function automatic logic [W-1:0] model_eval();
    logic [4:0] en;
    logic [3:0] fl;
    bit stall_mem, lu;
    stall_mem = mem_req && !mem_ready;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    en = 5'b11111; fl = 4'b0000;
    n_busy = m_busy; n_wait = m_wait; n_to = m_to;
    n_stalls = m_stalls; n_flushes = m_flushes;
    if (!rst_n) begin
      en = 5'b00000; n_busy = 0; n_wait = 0; n_to = 0;
      n_stalls = 0; n_flushes = 0;
    end else if (stall_mem) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (m_busy && !mdu_done) begin
      en = 5'b00011; fl = 4'b0010;
      n_wait = m_wait + 1;
      if (n_wait == MAX) begin n_to = 1; n_busy = 0; n_wait = 0; end
    end else if (m_busy) begin
      n_busy = 0; n_wait = 0;
    end else if (ex_br_taken) begin
      fl = 4'b1100; n_flushes = m_flushes + 1;
    end else if (ex_mdu_start && !mdu_done) begin
      en = 5'b00011; fl = 4'b0010; n_busy = 1; n_wait = 0;
    end else if (!ex_mdu_start && lu) begin
      en = 5'b00111; fl = 4'b0100;
    end
    if (rst_n && en[4] == 1'b0) n_stalls = m_stalls + 1;
    return {en, fl, m_to, m_busy};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst_n = 1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    ex_br_taken = 0; ex_mdu_start = 0; mdu_done = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // Let inputs settle mid-cycle and score the outputs against the model.
  task automatic eval();
    logic [W-1:0] e;
    #2;
    exp_q.push_back(model_eval());
    e = exp_q.pop_front();
    check("en",      {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e[10:6]});
    check("flush",   {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {28'd0, e[5:2]});
    check("timeout", {31'd0, mdu_timeout}, {31'd0, e[1]});
    check("state",   {31'd0, dbg_state}, {31'd0, e[0]});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check("perf_stall", perf_stall_cyc, m_stalls);
    check("perf_flush", perf_flush_cnt, m_flushes);
`endif
  endtask

  // Clock edge: commit the model, then return at the next falling edge.
  task automatic advance();
    @(posedge clk);
    m_busy = n_busy; m_wait = n_wait; m_to = n_to;
    m_stalls = n_stalls; m_flushes = n_flushes;
    @(negedge clk);
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Initial reset: hold through one edge so the state is known.
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    eval();
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    advance();

    // Idle after release: default outputs.
    idle_inputs();
    step();

    // Load-use: one bubble, then default once the load has moved on.
    idle_inputs(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    eval();
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    advance();
    idle_inputs(); id_rs1 = 5; id_use_rs1 = 1;
    eval();
    check("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    advance();

    // Load to x0 never stalls.
    idle_inputs(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    eval();
    check("lu_x0_pc_en", {31'd0, pc_en}, 32'd1);
    advance();

    // Branch outranks load-use.
    idle_inputs(); ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_br_taken = 1;
    eval();
    check("br_lu_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    check("br_lu_pc_en", {31'd0, pc_en}, 32'd1);
    advance();

    // MDU: start, three busy cycles, then done.
    idle_inputs(); ex_mdu_start = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      eval();
      check("mdu_busy_ex_mem_flush", {31'd0, ex_mem_flush}, 32'd1);
      advance();
    end
    mdu_done = 1;
    eval();
    check("mdu_done_pc_en", {31'd0, pc_en}, 32'd1);
    advance();
    idle_inputs();
    eval();
    check("mdu_after_state", {31'd0, dbg_state}, 32'd0);
    advance();

    // Memory wait inside MDU_BUSY, then run into the watchdog.
    idle_inputs(); ex_mdu_start = 1;
    step();
    idle_inputs();
    step();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("memwait_flags", {30'd0, mem_wb_flush, ex_mem_en}, 32'd2);
      advance();
    end
    idle_inputs();
    for (int i = 0; i < MAX - 1; i++) step();
    eval();
    check("wdog_timeout", {31'd0, mdu_timeout}, 32'd1);
    check("wdog_state", {31'd0, dbg_state}, 32'd0);
    advance();
    for (int i = 0; i < 3; i++) step();
    rst_n = 0;
    step();
    idle_inputs();
    eval();
    check("wdog_cleared", {31'd0, mdu_timeout}, 32'd0);
    advance();

    // Reset in the middle of an MDU operation.
    idle_inputs(); ex_mdu_start = 1;
    step();
    idle_inputs();
    step();
    rst_n = 0;
    eval();
    check("rst_mid_en", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'd0);
    advance();
    idle_inputs();
    eval();
    check("rst_mid_after", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'h1F);
    advance();

    // A branch held by a memory stall flushes once the stall clears.
    idle_inputs(); ex_br_taken = 1; mem_req = 1; mem_ready = 0;
    step();
    mem_ready = 1;
    eval();
    check("br_after_stall", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    advance();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      id_rs1       = AW'($urandom_range(0, 3));
      id_rs2       = AW'($urandom_range(0, 3));
      ex_rd        = AW'($urandom_range(0, 3));
      id_use_rs1   = $urandom_range(0, 1);
      id_use_rs2   = $urandom_range(0, 1);
      ex_is_load   = ($urandom_range(0, 2) == 0);
      ex_br_taken  = ($urandom_range(0, 7) == 0);
      ex_mdu_start = ($urandom_range(0, 9) == 0);
      mdu_done     = ($urandom_range(0, 9) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = $urandom_range(0, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. Each cycle it drives the enable and flush controls of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), covering:
- load-use hazards;
- taken-branch redirects;
- data-memory wait states;
- multi-cycle multiply/divide (MDU) operations.

It holds no datapath; it only decides when each stage register captures, holds or takes a bubble.

## Interface
- `REG_ADDR_W`, default 5: register-index width.
- `MDU_MAX_CYC`, default 64: MDU watchdog limit in cycles; must be ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `id_rs1`, `id_rs2` in `REG_ADDR_W`: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: ID instruction actually reads rs1/rs2.
- `ex_is_load` in 1: instruction in EX is a load.
- `ex_rd` in `REG_ADDR_W`: destination of the EX instruction.
- `ex_br_taken` in 1: EX resolved a taken branch or jump.
- `ex_mdu_start` in 1: EX issues an MDU operation (single-cycle pulse).
- `mdu_done` in 1: MDU result valid this cycle.
- `mem_req` in 1: MEM stage has an active data-memory access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: stage-register capture enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush` out 1: load a bubble (NOP) instead of data, qualified by the matching `_en`.
- `mdu_timeout` out 1: sticky watchdog error.

## Operation
- State register has two states, `RUN` and `MDU_BUSY`. All outputs are combinational from the state and the current inputs.
- Conditions evaluated each cycle:
  - `mem_stall` = `mem_req` & !`mem_ready`.
  - `load_use` = `ex_is_load` & (`ex_rd` ≠ 0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Default (`RUN`, no condition active): all `_en`=1, all `_flush`=0.
- Priority, highest first:
  1. **`mem_stall`**: `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `mem_wb_en`=1 with `mem_wb_flush`=1 (bubble into WB). Overrides every other condition in either state. The FSM does not change state, and the watchdog does not advance.
  2. **`MDU_BUSY` and !`mdu_done`**: `pc_en`, `if_id_en`, `id_ex_en` = 0; `ex_mem_en`=1 with `ex_mem_flush`=1; `mem_wb_en`=1.
  3. **`MDU_BUSY` and `mdu_done`**: default outputs; next state `RUN`.
  4. **`ex_br_taken`** (`RUN` only): all `_en`=1; `if_id_flush`=1, `id_ex_flush`=1 (two-instruction squash; PC loads the target).
  5. **`ex_mdu_start`** (`RUN` only): outputs as in case 2 this cycle; next state `MDU_BUSY`. If `mdu_done` is also high in the same cycle, default outputs apply and the state stays `RUN`.
  6. **`load_use`** (`RUN` only): `pc_en`=0, `if_id_en`=0; `id_ex_en`=1 with `id_ex_flush`=1. Outputs are default on the following cycle, since the load has moved to MEM.
- Branch has priority over load-use: the instruction in ID is squashed anyway.
- A branch that coincides with `mem_stall` is held in EX. Its flush is applied in the first cycle after the stall clears.
- Watchdog:
  - Counts cycles spent in `MDU_BUSY`.
  - At `MDU_MAX_CYC` it sets `mdu_timeout` and forces the state to `RUN`.
  - `mdu_timeout` clears only on reset.

## Timing
- Reset (`rst_n`=0 at a rising edge): state = `RUN`, watchdog = 0, `mdu_timeout`=0.
- While `rst_n` is low, all `_en`=0 and all `_flush`=0; stage registers reset themselves.
- Control latency is zero: enables and flushes respond in the same cycle as the inputs. State updates take effect next cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed slots. An MDU operation of N cycles (start to done) inserts N−1 bubbles into MEM.
- Reset asserted in `MDU_BUSY` returns to `RUN` at the next edge with no timeout flag.

## Configuration
- Macro `PIPE_HAZARD_CTRL_PERF_EN`, when defined, adds outputs:
  - `perf_stall_cyc` [31:0]: cycles with `pc_en`=0 while `rst_n`=1.
  - `perf_flush_cnt` [31:0]: cycles with `ex_br_taken` causing a flush.
- Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Without the macro, the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Load-use**: `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, then default. The same stimulus with `ex_rd`=0 → no stall.
- **Branch over load-use**: `ex_br_taken`=1 with a simultaneous load-use → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1.
- **MDU**: `ex_mdu_start` pulse, `mdu_done` 4 cycles later → 4 cycles with `pc_en`=0 and `ex_mem_flush`=1, done cycle default, state `RUN`.
- **Memory wait**: `mem_req`=1, `mem_ready`=0 for 3 cycles during `MDU_BUSY` → `mem_wb_flush`=1 and `ex_mem_en`=0 for 3 cycles; the watchdog count does not advance.
- **Watchdog**: `MDU_MAX_CYC`=8, no `mdu_done` → `mdu_timeout`=1 after 8 busy cycles, state `RUN`, flag held until `rst_n`=0.
- **Reset**: `rst_n` low mid-MDU → all `_en`=0 during reset; after release, default outputs.
